// File: rtl/reorient_tri.sv
// Triangle canonicaliser: rotates vertex labels cyclically so that PQ is the
// longest XY-projected edge, keeping winding order and coordinate bits intact.
package reorient_tri_pkg;
    localparam int unsigned COORD_W = 16;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } point3d_t;

    typedef struct packed {
        point3d_t p;
        point3d_t q;
        point3d_t r;
    } triangle3d_t;
endpackage

module reorient_tri
    import reorient_tri_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  triangle3d_t tri_in,
    output triangle3d_t tri_out
);

    localparam int unsigned DIFF_W = COORD_W + 1;
    localparam int unsigned SQ_W   = 2 * DIFF_W;
    localparam int unsigned SUM_W  = SQ_W + 1;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PQ   = 2'd1,
        SEL_QR   = 2'd2,
        SEL_RP   = 2'd3
    } sel_e;

    // Squared XY distance; widths chosen so no 16-bit input can overflow.
    function automatic logic [SUM_W-1:0] dist2(input point3d_t a, input point3d_t b);
        logic signed [DIFF_W-1:0] dx;
        logic signed [DIFF_W-1:0] dy;
        logic signed [SQ_W-1:0]   sx;
        logic signed [SQ_W-1:0]   sy;
        dx = DIFF_W'($signed(a.x)) - DIFF_W'($signed(b.x));
        dy = DIFF_W'($signed(a.y)) - DIFF_W'($signed(b.y));
        sx = SQ_W'(dx) * SQ_W'(dx);
        sy = SQ_W'(dy) * SQ_W'(dy);
        return SUM_W'($unsigned(sx)) + SUM_W'($unsigned(sy));
    endfunction

    logic [SUM_W-1:0] w_d1;
    logic [SUM_W-1:0] w_d2;
    logic [SUM_W-1:0] w_d3;
    sel_e             w_sel;
    triangle3d_t      w_tri_rot;

    triangle3d_t      r_tri;
    sel_e             r_sel;
    triangle3d_t      r_tri_out;

    // Stage 1 selector: strict compares, ties fall toward the later edge.
    always_comb begin
        w_d1 = dist2(tri_in.p, tri_in.q);
        w_d2 = dist2(tri_in.q, tri_in.r);
        w_d3 = dist2(tri_in.r, tri_in.p);
        if (w_d1 > w_d2) begin
            w_sel = (w_d1 > w_d3) ? SEL_PQ : SEL_RP;
        end else begin
            w_sel = (w_d2 > w_d3) ? SEL_QR : SEL_RP;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tri <= '0;
            r_sel <= SEL_NONE;
        end else begin
            r_tri <= tri_in;
            r_sel <= w_sel;
        end
    end

    // Stage 2 rotation: whole vertices move, order preserved cyclically.
    always_comb begin
        w_tri_rot = r_tri;
        case (r_sel)
            SEL_QR: begin
                w_tri_rot.p = r_tri.q;
                w_tri_rot.q = r_tri.r;
                w_tri_rot.r = r_tri.p;
            end
            SEL_RP: begin
                w_tri_rot.p = r_tri.r;
                w_tri_rot.q = r_tri.p;
                w_tri_rot.r = r_tri.q;
            end
            default: w_tri_rot = r_tri;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tri_out <= '0;
        end else begin
            r_tri_out <= w_tri_rot;
        end
    end

    assign tri_out = r_tri_out;

endmodule

// File: tb/tb_reorient_tri.sv
// Directed and streaming bench for reorient_tri with a behavioural selector model.
module tb_reorient_tri;
    import reorient_tri_pkg::*;

    logic        clk;
    logic        n_rst;
    triangle3d_t tri_in;
    triangle3d_t tri_out;

    int n_vec;
    int n_err;

    reorient_tri dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .tri_in (tri_in),
        .tri_out(tri_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic point3d_t pt(input int x, input int y, input int z);
        point3d_t v;
        v.x = 16'(x);
        v.y = 16'(y);
        v.z = 16'(z);
        return v;
    endfunction

    function automatic triangle3d_t mk(input point3d_t p, input point3d_t q, input point3d_t r);
        triangle3d_t t;
        t.p = p;
        t.q = q;
        t.r = r;
        return t;
    endfunction

    function automatic longint d2(input point3d_t a, input point3d_t b);
        longint dx;
        longint dy;
        dx = longint'(a.x) - longint'(b.x);
        dy = longint'(a.y) - longint'(b.y);
        return dx * dx + dy * dy;
    endfunction

    function automatic triangle3d_t model(input triangle3d_t t);
        longint a;
        longint b;
        longint c;
        a = d2(t.p, t.q);
        b = d2(t.q, t.r);
        c = d2(t.r, t.p);
        if (a > b && a > c) return t;
        if (a <= b && b > c) return mk(t.q, t.r, t.p);
        return mk(t.r, t.p, t.q);
    endfunction

    function automatic triangle3d_t gen(input int i);
        return mk(pt(-(10 + 2 * i), -(3 + 30 * i), -(23 + 5 * i)),
                  pt(16 + 7 * i, 32 + 32 * i, 9 * i),
                  pt(int'($urandom_range(65535)), int'($urandom_range(65535)),
                     int'($urandom_range(65535))));
    endfunction

    task automatic check(input string tag, input triangle3d_t exp);
        n_vec++;
        assert (tri_out === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, tri_out, exp);
        end
    endtask

    // One directed vector: one-cycle pulse, checked before, at and after latency.
    task automatic directed(input string tag, input triangle3d_t v, input triangle3d_t exp);
        @(negedge clk);
        tri_in = v;
        @(negedge clk);
        tri_in = '0;
        check({tag, "_early"}, '0);
        @(negedge clk);
        check(tag, exp);
        @(negedge clk);
        check({tag, "_after"}, '0);
    endtask

    task automatic run_stream(input int base, input int n, input bit drain);
        triangle3d_t hist[$];
        int last;
        last = drain ? n + 2 : n;
        for (int k = 0; k < last; k++) begin
            @(negedge clk);
            if (k >= 2) check("stream", model(hist[k-2]));
            else        check("stream_fill", '0);
            if (k < n) begin
                hist.push_back(gen(base + k));
                tri_in = hist[k];
            end else begin
                tri_in = '0;
            end
        end
    endtask

    initial begin
        triangle3d_t t;
        n_vec  = 0;
        n_err  = 0;
        n_rst  = 1'b0;
        tri_in = mk(pt(1234, -55, 9), pt(-800, 77, 3), pt(42, 42, 42));

        repeat (3) @(negedge clk);
        check("reset_hold", '0);
        tri_in = mk(pt(-1, 2, -3), pt(400, -500, 6), pt(7, 8000, -9));
        @(negedge clk);
        check("reset_hold2", '0);

        n_rst  = 1'b1;
        tri_in = '0;
        @(negedge clk);
        check("post_release_1", '0);
        @(negedge clk);
        check("post_release_2", '0);

        t = mk(pt(0, 0, 0), pt(10, 0, 0), pt(5, 1, 0));
        directed("pq_longest", t, t);

        directed("qr_longest", mk(pt(0, 0, 5), pt(10, 0, 6), pt(0, 1, 7)),
                 mk(pt(10, 0, 6), pt(0, 1, 7), pt(0, 0, 5)));

        directed("rp_longest", mk(pt(0, 0, 0), pt(0, 1, 0), pt(0, 10, 0)),
                 mk(pt(0, 10, 0), pt(0, 0, 0), pt(0, 1, 0)));

        t = mk(pt(-16383, -16383, -16383), pt(16383, 16383, 16383), pt(-16383, 16383, -16383));
        directed("extremes", t, t);

        t = mk(pt(-32768, -32768, 1), pt(32767, 32767, 2), pt(0, 0, 3));
        directed("full_range", t, t);

        t = mk(pt(7, 7, 7), pt(7, 7, 7), pt(7, 7, 7));
        directed("degenerate", t, t);

        directed("tie_d1_eq_d2", mk(pt(1, 0, 1), pt(0, 5, 2), pt(-1, 0, 3)),
                 mk(pt(0, 5, 2), pt(-1, 0, 3), pt(1, 0, 1)));

        directed("tie_d1_eq_d3", mk(pt(0, 5, 1), pt(1, 0, 2), pt(-1, 0, 3)),
                 mk(pt(-1, 0, 3), pt(0, 5, 1), pt(1, 0, 2)));

        run_stream(0, 500, 1'b0);

        #2 n_rst = 1'b0;
        #1 check("async_reset", '0);
        @(negedge clk);
        check("reset_mid", '0);
        @(negedge clk);
        n_rst  = 1'b1;
        tri_in = '0;

        run_stream(500, 500, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
